// File: rtl/isa_bus_pkg.sv
// ---------------------------------------------------------------------------
// isa_bus_pkg
// Shared definitions for the ISA I/O write master and its request FIFO:
// bus widths, the port 80h POST-code address, the write-cycle FSM state
// enum, the packed request record and a helper for phase counter loads.
// ---------------------------------------------------------------------------
package isa_bus_pkg;

    localparam int ISA_ADDR_W = 20;
    localparam int ISA_DATA_W = 8;
    localparam int REQ_W      = ISA_ADDR_W + ISA_DATA_W;

    // Phase counter width; wide enough for any cycle-length parameter.
    localparam int CNT_W = 8;

    localparam logic [ISA_ADDR_W-1:0] Port80Addr = 20'h00080;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CMD,
        HOLD,
        RECOVER
    } isa_state_t;

    typedef struct packed {
        logic [ISA_ADDR_W-1:0] addr;
        logic [ISA_DATA_W-1:0] data;
    } isa_req_t;

    // A phase lasting N clocks counts down from N-1 to 0.
    function automatic logic [CNT_W-1:0] phase_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/isa_req_fifo.sv
// ---------------------------------------------------------------------------
// isa_req_fifo
// Synchronous first-word-fall-through FIFO holding queued write requests.
// Depth must be a power of two so the pointers wrap naturally.
//   clock, reset : clock and synchronous active-high reset (flushes FIFO)
//   push, wdata  : write request; ignored when full
//   pop          : consume the head entry; ignored when empty
//   rdata        : current head entry (valid while !empty)
//   full, empty  : occupancy flags derived from the registered count
//   count        : number of stored entries
// ---------------------------------------------------------------------------
module isa_req_fifo
    import isa_bus_pkg::*;
#(
    parameter int Depth = 4,
    parameter int Width = REQ_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic [Width-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int PtrW   = $clog2(Depth);
    localparam int CountW = $clog2(Depth + 1);

    logic [Width-1:0]  mem [Depth];
    logic [PtrW-1:0]   rd_ptr;
    logic [PtrW-1:0]   wr_ptr;
    logic [CountW-1:0] count_q;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CountW'(1);
                2'b01:   count_q <= count_q - CountW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count_q == CountW'(Depth));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/isa_io_write_master.sv
// ---------------------------------------------------------------------------
// isa_io_write_master
// ISA 8-bit I/O write initiator. Queued (address, data) requests are turned
// into complete I/O write cycles: BALE pulse, SA/SD drive, IOW strobe, data
// hold and a recovery gap before the next cycle.
//   Clock, Reset    : clock and synchronous active-high reset
//   ReqValid/Ready  : request handshake; ReqReady is low while FIFO is full
//   ReqAddr/ReqData : I/O address and write data of the request
//   SA, SD, SDOe    : ISA address, data and data-buffer drive enable
//   BALE            : address latch enable, active high
//   IOW             : I/O write strobe, active low
//   AEN             : low while this master owns the bus cycle
//   SBHE            : tied high, only 8-bit transfers are issued
//   Busy            : a cycle is in progress or requests are queued
//   Done            : one-clock pulse as each cycle's recovery ends
// ---------------------------------------------------------------------------
module isa_io_write_master
    import isa_bus_pkg::*;
#(
    parameter int FifoDepth     = 4,
    parameter int BaleCycles    = 2,
    parameter int IowCycles     = 6,
    parameter int HoldCycles    = 1,
    parameter int RecoverCycles = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [ISA_ADDR_W-1:0] ReqAddr,
    input  logic [ISA_DATA_W-1:0] ReqData,
    output logic [ISA_ADDR_W-1:0] SA,
    output logic [ISA_DATA_W-1:0] SD,
    output logic                  SDOe,
    output logic                  BALE,
    output logic                  IOW,
    output logic                  AEN,
    output logic                  SBHE,
    output logic                  Busy,
    output logic                  Done
);

    localparam int FifoCountW = $clog2(FifoDepth + 1);

    isa_state_t            state;
    isa_state_t            state_next;
    logic [CNT_W-1:0]      counter;
    logic [CNT_W-1:0]      counter_next;

    logic [REQ_W-1:0]      fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FifoCountW-1:0] fifo_count;
    isa_req_t              head;

    logic                  phase_end;
    logic                  start;

    logic [ISA_ADDR_W-1:0] sa_next;
    logic [ISA_DATA_W-1:0] sd_next;
    logic                  sdoe_next;
    logic                  bale_next;
    logic                  iow_next;
    logic                  aen_next;
    logic                  done_next;

    isa_req_fifo #(
        .Depth (FifoDepth),
        .Width (REQ_W)
    ) u_fifo (
        .clock (Clock),
        .reset (Reset),
        .push  (ReqValid),
        .wdata ({ReqAddr, ReqData}),
        .pop   (start),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head      = isa_req_t'(fifo_rdata);
    assign phase_end = (counter == '0);

    // A new cycle starts from IDLE, or straight out of the last recovery
    // clock so back-to-back requests are spaced by exactly RecoverCycles
    // idle clocks rather than one extra IDLE clock.
    assign start = !fifo_empty && ((state == IDLE) || ((state == RECOVER) && phase_end));

    assign ReqReady = !fifo_full;
    assign Busy     = (state != IDLE) || (fifo_count != '0);
    assign SBHE     = 1'b1;

    // State, phase counter and all bus outputs are registered here.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            counter <= '0;
            SA      <= '0;
            SD      <= '0;
            SDOe    <= 1'b0;
            BALE    <= 1'b0;
            IOW     <= 1'b1;
            AEN     <= 1'b1;
            Done    <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            SA      <= sa_next;
            SD      <= sd_next;
            SDOe    <= sdoe_next;
            BALE    <= bale_next;
            IOW     <= iow_next;
            AEN     <= aen_next;
            Done    <= done_next;
        end
    end

    // Each phase counts down from its length minus one, then advances.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = ADDR;
                    counter_next = phase_load(BaleCycles);
                end
            end
            ADDR: begin
                if (phase_end) begin
                    state_next   = CMD;
                    counter_next = phase_load(IowCycles);
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end
            CMD: begin
                if (phase_end) begin
                    state_next   = HOLD;
                    counter_next = phase_load(HoldCycles);
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_next   = RECOVER;
                    counter_next = phase_load(RecoverCycles);
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (phase_end) begin
                    if (start) begin
                        state_next   = ADDR;
                        counter_next = phase_load(BaleCycles);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                counter_next = '0;
            end
        endcase
    end

    // Bus signals change only at phase boundaries; SA and SD keep their
    // last values between cycles.
    always_comb begin
        sa_next   = SA;
        sd_next   = SD;
        sdoe_next = SDOe;
        bale_next = BALE;
        iow_next  = IOW;
        aen_next  = AEN;
        done_next = 1'b0;

        if (start) begin
            sa_next   = head.addr;
            sd_next   = head.data;
            sdoe_next = 1'b1;
            aen_next  = 1'b0;
            bale_next = 1'b1;
        end

        case (state)
            ADDR: begin
                if (phase_end) begin
                    bale_next = 1'b0;
                    iow_next  = 1'b0;
                end
            end
            CMD: begin
                if (phase_end) begin
                    iow_next = 1'b1;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    sdoe_next = 1'b0;
                    aen_next  = 1'b1;
                end
            end
            RECOVER: begin
                if (phase_end) begin
                    done_next = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_isa_io_write_master.sv
// ---------------------------------------------------------------------------
// tb_isa_io_write_master
// Drives two masters (default timing and all-phases-one-clock) from the same
// request stream. A transaction-level model (request queue plus time since
// BALE rose) predicts every output each clock; directed tests add literal
// expectations for waveform timing, ordering, reset and a port 80h snooper.
// ---------------------------------------------------------------------------
module tb_isa_io_write_master;
    import isa_bus_pkg::*;

    localparam int DEPTH = 4;
    localparam int B0 = 2, I0 = 6, H0 = 1, R0 = 3;
    localparam int B1 = 1, I1 = 1, H1 = 1, R1 = 1;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic [19:0] ReqAddr = '0;
    logic [7:0]  ReqData = '0;

    logic        ready0, sdoe0, bale0, iow0, aen0, sbhe0, busy0, done0;
    logic [19:0] sa0;
    logic [7:0]  sd0;
    logic        ready1, sdoe1, bale1, iow1, aen1, sbhe1, busy1, done1;
    logic [19:0] sa1;
    logic [7:0]  sd1;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    isa_io_write_master #(
        .FifoDepth(DEPTH), .BaleCycles(B0), .IowCycles(I0),
        .HoldCycles(H0), .RecoverCycles(R0)
    ) u_dut0 (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ready0),
        .ReqAddr(ReqAddr), .ReqData(ReqData), .SA(sa0), .SD(sd0), .SDOe(sdoe0),
        .BALE(bale0), .IOW(iow0), .AEN(aen0), .SBHE(sbhe0), .Busy(busy0), .Done(done0)
    );

    isa_io_write_master #(
        .FifoDepth(DEPTH), .BaleCycles(B1), .IowCycles(I1),
        .HoldCycles(H1), .RecoverCycles(R1)
    ) u_dut1 (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ready1),
        .ReqAddr(ReqAddr), .ReqData(ReqData), .SA(sa1), .SD(sd1), .SDOe(sdoe1),
        .BALE(bale1), .IOW(iow1), .AEN(aen1), .SBHE(sbhe1), .Busy(busy1), .Done(done1)
    );

    function automatic int bale_len(input int i); return (i == 0) ? B0 : B1; endfunction
    function automatic int iow_len(input int i);  return (i == 0) ? I0 : I1; endfunction
    function automatic int hold_len(input int i); return (i == 0) ? H0 : H1; endfunction
    function automatic int rec_len(input int i);  return (i == 0) ? R0 : R1; endfunction

    // {BALE, IOW, AEN, SDOe, Done, Busy, ReqReady}
    function automatic logic [6:0] act_ctl(input int i);
        if (i == 0) return {bale0, iow0, aen0, sdoe0, done0, busy0, ready0};
        return {bale1, iow1, aen1, sdoe1, done1, busy1, ready1};
    endfunction
    function automatic logic [19:0] act_sa(input int i); return (i == 0) ? sa0 : sa1; endfunction
    function automatic logic [7:0]  act_sd(input int i); return (i == 0) ? sd0 : sd1; endfunction
    function automatic logic        act_sbhe(input int i); return (i == 0) ? sbhe0 : sbhe1; endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUTs at each rising edge.
    logic        s_reset, s_valid;
    logic [27:0] s_req;
    always @(posedge Clock) begin
        s_reset <= Reset;
        s_valid <= ReqValid;
        s_req   <= {ReqAddr, ReqData};
    end

    // Behavioural model: a request ring, plus clocks elapsed since BALE rose.
    int          m_count [2] = '{0, 0};
    int          m_head  [2] = '{0, 0};
    int          m_t     [2] = '{0, 0};
    bit          m_act   [2] = '{1'b0, 1'b0};
    bit          m_done  [2] = '{1'b0, 1'b0};
    logic [27:0] m_q     [2][DEPTH];
    logic [19:0] m_sa    [2] = '{20'h0, 20'h0};
    logic [7:0]  m_sd    [2] = '{8'h0, 8'h0};

    task automatic modelStep(input int i);
        int          len;
        bit          had, was_full;
        logic [27:0] entry;
        len = bale_len(i) + iow_len(i) + hold_len(i) + rec_len(i);
        if (s_reset === 1'b1) begin
            m_count[i] = 0; m_head[i] = 0; m_t[i] = 0;
            m_act[i] = 1'b0; m_done[i] = 1'b0;
            m_sa[i] = '0; m_sd[i] = '0;
        end else begin
            had      = (m_count[i] > 0);
            was_full = (m_count[i] == DEPTH);
            m_done[i] = 1'b0;
            if (m_act[i]) begin
                m_t[i]++;
                if (m_t[i] == len) begin
                    m_act[i]  = 1'b0;
                    m_done[i] = 1'b1;
                end
            end
            if (!m_act[i] && had) begin
                entry      = m_q[i][m_head[i]];
                m_head[i]  = (m_head[i] + 1) % DEPTH;
                m_count[i] = m_count[i] - 1;
                m_act[i]   = 1'b1;
                m_t[i]     = 0;
                m_sa[i]    = entry[27:8];
                m_sd[i]    = entry[7:0];
            end
            if (s_valid === 1'b1 && !was_full) begin
                m_q[i][(m_head[i] + m_count[i]) % DEPTH] = s_req;
                m_count[i] = m_count[i] + 1;
            end
        end
    endtask

    // DUT0 monitors: codes seen at each IOW fall, idle gap lengths, snoopers.
    logic [7:0] cap0[$];
    int         gaps0[$];
    logic [7:0] snoop [2] = '{8'h00, 8'h00};
    logic       prev_iow [2] = '{1'b1, 1'b1};
    logic       prev_aen0 = 1'b1;
    bit         in_gap = 1'b0;
    int         gap_run = 0;

    initial begin
        forever begin
            @(negedge Clock);
            for (int i = 0; i < 2; i++) begin
                int   t, b, w, h;
                logic e_bale, e_iow, e_drive;
                modelStep(i);
                t = m_t[i]; b = bale_len(i); w = iow_len(i); h = hold_len(i);
                e_bale  = m_act[i] && (t < b);
                e_iow   = !(m_act[i] && (t >= b) && (t < b + w));
                e_drive = m_act[i] && (t < b + w + h);
                checkOutput($sformatf("d%0d_ctl", i), 32'(act_ctl(i)),
                            32'({e_bale, e_iow, !e_drive, e_drive, m_done[i],
                                 (m_act[i] || m_count[i] > 0), (m_count[i] != DEPTH)}));
                checkOutput($sformatf("d%0d_sa", i), 32'(act_sa(i)), 32'(m_sa[i]));
                if (e_drive) checkOutput($sformatf("d%0d_sd", i), 32'(act_sd(i)), 32'(m_sd[i]));
                checkOutput($sformatf("d%0d_sbhe", i), 32'(act_sbhe(i)), 32'h1);
                checkOutput($sformatf("d%0d_invariant", i),
                            32'(!(act_ctl(i)[6] && !act_ctl(i)[5]) &&
                                (act_ctl(i)[5] || !act_ctl(i)[4]) &&
                                (act_ctl(i)[5] || act_ctl(i)[3])), 32'h1);
                if (!prev_iow[i] && act_ctl(i)[5] && !act_ctl(i)[4] && act_sa(i) == Port80Addr)
                    snoop[i] = act_sd(i);
                prev_iow[i] = act_ctl(i)[5];
            end
            if (prev_iow[0] == 1'b0 && cap0.size() >= 0) begin
            end
            if (!busy0) in_gap = 1'b0;
            else if (aen0 && !prev_aen0) begin in_gap = 1'b1; gap_run = 1; end
            else if (aen0 && in_gap) gap_run++;
            else if (!aen0 && prev_aen0 && in_gap) begin gaps0.push_back(gap_run); in_gap = 1'b0; end
            prev_aen0 = aen0;
        end
    end

    // IOW falling edge capture for DUT0 (prev value tracked separately here).
    logic cap_prev_iow = 1'b1;
    initial begin
        forever begin
            @(negedge Clock);
            if (cap_prev_iow && !iow0) cap0.push_back(sd0);
            cap_prev_iow = iow0;
        end
    end

    // Presents one request across exactly one rising edge; called at a negedge.
    task automatic applyStimulus(input logic [19:0] a, input logic [7:0] d);
        ReqValid = 1'b1; ReqAddr = a; ReqData = d;
        @(negedge Clock);
        ReqValid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((busy0 || busy1) && n < budget) begin
            @(negedge Clock);
            n++;
        end
        checkOutput("idle_timeout", 32'(busy0 || busy1), 32'h0);
        repeat (2) @(negedge Clock);
    endtask

    // One isolated write on both DUTs; timing measured from the push edge.
    task automatic measureCycle(input string tag, input logic [19:0] a, input logic [7:0] d);
        int          bale_first [2] = '{-1, -1};
        int          bale_n [2] = '{0, 0};
        int          iow_n [2] = '{0, 0};
        int          done_at [2] = '{-1, -1};
        logic [19:0] sa_low [2] = '{20'hx, 20'hx};
        logic [7:0]  sd_low [2] = '{8'hx, 8'hx};
        applyStimulus(a, d);
        for (int j = 1; j <= 20; j++) begin
            @(negedge Clock);
            for (int i = 0; i < 2; i++) begin
                if (act_ctl(i)[6]) begin
                    bale_n[i]++;
                    if (bale_first[i] < 0) bale_first[i] = j;
                end
                if (!act_ctl(i)[5]) begin
                    if (iow_n[i] == 0) begin sa_low[i] = act_sa(i); sd_low[i] = act_sd(i); end
                    iow_n[i]++;
                end
                if (act_ctl(i)[2] && done_at[i] < 0) done_at[i] = j;
            end
        end
        checkOutput({tag, "_bale_rise_d0"}, 32'(bale_first[0]), 32'd1);
        checkOutput({tag, "_bale_clocks_d0"}, 32'(bale_n[0]), 32'd2);
        checkOutput({tag, "_iow_clocks_d0"}, 32'(iow_n[0]), 32'd6);
        checkOutput({tag, "_done_delay_d0"}, 32'(done_at[0] - bale_first[0]), 32'd12);
        checkOutput({tag, "_sa_d0"}, 32'(sa_low[0]), 32'(a));
        checkOutput({tag, "_sd_d0"}, 32'(sd_low[0]), 32'(d));
        checkOutput({tag, "_bale_clocks_d1"}, 32'(bale_n[1]), 32'd1);
        checkOutput({tag, "_iow_clocks_d1"}, 32'(iow_n[1]), 32'd1);
        checkOutput({tag, "_done_delay_d1"}, 32'(done_at[1] - bale_first[1]), 32'd4);
        checkOutput({tag, "_sa_d1"}, 32'(sa_low[1]), 32'(a));
    endtask

    task automatic checkCodes(input string tag, input logic [7:0] first, input int n);
        logic [7:0] got;
        checkOutput({tag, "_code_count"}, 32'(cap0.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            got = 8'hxx;
            if (k < cap0.size()) got = cap0[k];
            checkOutput($sformatf("%s_code%0d", tag, k), 32'(got), 32'(first + 8'(k)));
        end
        checkOutput({tag, "_gap_count"}, 32'(gaps0.size()), 32'(n - 1));
        for (int k = 0; k < gaps0.size(); k++)
            checkOutput($sformatf("%s_gap%0d", tag, k), 32'(gaps0[k]), 32'd3);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        checkOutput("rst_ctl_d0", 32'(act_ctl(0)), 32'b0110001);
        checkOutput("rst_ctl_d1", 32'(act_ctl(1)), 32'b0110001);
        checkOutput("rst_sa_d0", 32'(sa0), 32'h0);
        checkOutput("rst_sd_d0", 32'(sd0), 32'h0);
        checkOutput("rst_sbhe_d0", 32'(sbhe0), 32'h1);
        Reset = 1'b0;
        @(negedge Clock);

        $display("[TB] single write to port 80h");
        cap0.delete(); gaps0.delete();
        measureCycle("t1", Port80Addr, 8'h5A);
        waitIdle(40);
        checkOutput("t1_snoop_d0", 32'(snoop[0]), 32'h5A);
        checkOutput("t1_snoop_d1", 32'(snoop[1]), 32'h5A);

        $display("[TB] burst of five codes");
        cap0.delete(); gaps0.delete();
        for (int k = 1; k <= 5; k++) applyStimulus(Port80Addr, 8'(k));
        checkOutput("t2_ready_full_d0", 32'(ready0), 32'h0);
        waitIdle(200);
        checkCodes("t2", 8'h01, 5);

        $display("[TB] push coinciding with pop at count 3");
        cap0.delete(); gaps0.delete();
        for (int k = 0; k < 4; k++) applyStimulus(Port80Addr, 8'h11 + 8'(k));
        repeat (9) @(negedge Clock);
        applyStimulus(Port80Addr, 8'h15);
        checkOutput("t3_ready_after_pushpop", 32'(ready0), 32'h1);
        applyStimulus(Port80Addr, 8'h16);
        checkOutput("t3_ready_now_full", 32'(ready0), 32'h0);
        waitIdle(300);
        checkCodes("t3", 8'h11, 6);

        $display("[TB] reset during IOW strobe");
        applyStimulus(Port80Addr, 8'hC3);
        applyStimulus(Port80Addr, 8'hC4);
        repeat (4) @(negedge Clock);
        checkOutput("t4_iow_low_before_reset", 32'(iow0), 32'h0);
        checkOutput("t4_busy_before_reset", 32'(busy0), 32'h1);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        checkOutput("t4_ctl_after_reset_d0", 32'(act_ctl(0)), 32'b0110001);
        checkOutput("t4_ctl_after_reset_d1", 32'(act_ctl(1)), 32'b0110001);
        begin
            bit seen = 1'b0;
            for (int j = 0; j < 20; j++) begin
                @(negedge Clock);
                if (bale0 || done0 || bale1 || done1) seen = 1'b1;
            end
            checkOutput("t4_no_activity_after_reset", 32'(seen), 32'h0);
        end
        checkOutput("t4_snoop_d0", 32'(snoop[0]), 32'h16);
        checkOutput("t4_snoop_d1", 32'(snoop[1]), 32'hC3);

        $display("[TB] write to 378h");
        cap0.delete(); gaps0.delete();
        measureCycle("t5", 20'h00378, 8'h99);
        waitIdle(40);
        checkOutput("t5_snoop_d0", 32'(snoop[0]), 32'h16);
        checkOutput("t5_snoop_d1", 32'(snoop[1]), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
